// File: rtl/clock_pkg.sv
// Shared definitions for the display path: scan FSM encoding, 7-segment glyphs
// (active-high, bit order g..a) and the digit-position indices of the clock face.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SHOW   = 2'd2,
        ST_BLANK  = 2'd3
    } scan_state_e;

    localparam logic [6:0] GLYPH_0     = 7'h3F;
    localparam logic [6:0] GLYPH_1     = 7'h06;
    localparam logic [6:0] GLYPH_2     = 7'h5B;
    localparam logic [6:0] GLYPH_3     = 7'h4F;
    localparam logic [6:0] GLYPH_4     = 7'h66;
    localparam logic [6:0] GLYPH_5     = 7'h6D;
    localparam logic [6:0] GLYPH_6     = 7'h7D;
    localparam logic [6:0] GLYPH_7     = 7'h07;
    localparam logic [6:0] GLYPH_8     = 7'h7F;
    localparam logic [6:0] GLYPH_9     = 7'h6F;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    localparam logic [3:0] HOURS_MSD   = 4'd0;
    localparam logic [3:0] HOURS_LSD   = 4'd1;
    localparam logic [3:0] MINUTES_MSD = 4'd2;
    localparam logic [3:0] MINUTES_LSD = 4'd3;
    localparam logic [3:0] SECONDS_MSD = 4'd4;
    localparam logic [3:0] SECONDS_LSD = 4'd5;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Digit-scan bus between the BCD source, the scan driver and the display pins.
// master = scan driver side, slave = BCD source / display side.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 6
);
    logic                  i_en;
    logic                  i_refresh_stb;
    logic [3:0]            i_bcd;
    logic                  i_dp;
    logic [3:0]            o_seg_select;
    logic [7:0]            o_segments;
    logic [NUM_DIGITS-1:0] o_digit_en;

    modport master (
        input  i_en, i_refresh_stb, i_bcd, i_dp,
        output o_seg_select, o_segments, o_digit_en
    );

    modport slave (
        output i_en, i_refresh_stb, i_bcd, i_dp,
        input  o_seg_select, o_segments, o_digit_en
    );
endinterface

// File: rtl/seg7_scan_driver_bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder; non-decimal codes render dark.
module bcd_to_7seg
    import clock_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_dp,
    output logic [7:0] o_segments
);

    // Glyph lookup with the decimal point carried on bit 7
    always_comb begin
        o_segments = {i_dp, GLYPH_BLANK};
        case (i_bcd)
            4'd0:    o_segments = {i_dp, GLYPH_0};
            4'd1:    o_segments = {i_dp, GLYPH_1};
            4'd2:    o_segments = {i_dp, GLYPH_2};
            4'd3:    o_segments = {i_dp, GLYPH_3};
            4'd4:    o_segments = {i_dp, GLYPH_4};
            4'd5:    o_segments = {i_dp, GLYPH_5};
            4'd6:    o_segments = {i_dp, GLYPH_6};
            4'd7:    o_segments = {i_dp, GLYPH_7};
            4'd8:    o_segments = {i_dp, GLYPH_8};
            4'd9:    o_segments = {i_dp, GLYPH_9};
            default: o_segments = {i_dp, GLYPH_BLANK};
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: settle, show, blank per digit, one-hot enables.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN darkens a leading zero on the hours MSD.
module seg7_scan_driver
    import clock_pkg::*;
#(
    parameter int NUM_DIGITS   = 6,
    parameter int BLANK_CYCLES = 4
) (
    input logic                i_clk,
    input logic                i_rst,
    seg7_scan_driver_if.master bus
);

    localparam logic [7:0]            BLANK_LOAD = 8'(BLANK_CYCLES - 1);
    localparam logic [3:0]            LAST_SEL   = 4'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE_LSB    = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    scan_state_e           state_r,      state_s;
    logic [3:0]            seg_select_r, seg_select_s;
    logic [7:0]            segments_r,   segments_s;
    logic [NUM_DIGITS-1:0] digit_en_r,   digit_en_s;
    logic [7:0]            blank_cnt_r,  blank_cnt_s;
    logic [7:0]            decoded_s;
    logic [7:0]            settle_seg_s;
    logic                  lz_blank_s;

    bcd_to_7seg u_decode (
        .i_bcd      (bus.i_bcd),
        .i_dp       (bus.i_dp),
        .o_segments (decoded_s)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    assign lz_blank_s = (seg_select_r == HOURS_MSD) && (bus.i_bcd == 4'd0);
`else
    assign lz_blank_s = 1'b0;
`endif

    assign settle_seg_s = lz_blank_s ? {decoded_s[7], GLYPH_BLANK} : decoded_s;

    // Next-state and next-output logic; disable outranks everything but reset
    always_comb begin
        state_s      = state_r;
        seg_select_s = seg_select_r;
        segments_s   = segments_r;
        digit_en_s   = digit_en_r;
        blank_cnt_s  = blank_cnt_r;
        if (!bus.i_en) begin
            state_s    = ST_IDLE;
            digit_en_s = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s    = ST_SETTLE;
                    digit_en_s = '0;
                end
                ST_SETTLE: begin
                    state_s    = ST_SHOW;
                    segments_s = settle_seg_s;
                    digit_en_s = ONE_LSB << seg_select_r;
                end
                ST_SHOW: begin
                    if (bus.i_refresh_stb) begin
                        state_s     = ST_BLANK;
                        digit_en_s  = '0;
                        blank_cnt_s = BLANK_LOAD;
                    end else begin
                        state_s = ST_SHOW;
                    end
                end
                ST_BLANK: begin
                    // Select moves only while dark so the BCD source has a full settle cycle
                    if (blank_cnt_r == 8'd0) begin
                        state_s = ST_SETTLE;
                        if (seg_select_r == LAST_SEL) begin
                            seg_select_s = 4'd0;
                        end else begin
                            seg_select_s = seg_select_r + 4'd1;
                        end
                    end else begin
                        blank_cnt_s = blank_cnt_r - 8'd1;
                    end
                end
                default: begin
                    state_s    = ST_IDLE;
                    digit_en_s = '0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            seg_select_r <= 4'd0;
            segments_r   <= 8'h00;
            digit_en_r   <= '0;
            blank_cnt_r  <= 8'd0;
        end else begin
            state_r      <= state_s;
            seg_select_r <= seg_select_s;
            segments_r   <= segments_s;
            digit_en_r   <= digit_en_s;
            blank_cnt_r  <= blank_cnt_s;
        end
    end

    assign bus.o_seg_select = seg_select_r;
    assign bus.o_segments   = segments_r;
    assign bus.o_digit_en   = digit_en_r;

endmodule
